// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the data cache.
// Imported by the controller and its tag/data array.
package dcache_pkg;

    localparam int OFF_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_RREQ,
        S_RFILL,
        S_WREQ,
        S_DONE
    } state_t;

    function automatic int tag_w(input int lines, input int words);
        return 32 - OFF_W - $clog2(words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Synchronous-read tag and data storage with per-byte data write enables.
// Contents are not reset; line validity is tracked by the controller.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int IDX_W = 6,
    parameter int WRD_W = 2,
    parameter int TAG_W = 22
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [WRD_W-1:0] rd_word_i,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [WRD_W-1:0] wr_word_i,
    input  logic [3:0]       wr_be_i,
    input  logic [31:0]      wr_data_i,
    input  logic             tag_we_i,
    input  logic [TAG_W-1:0] wr_tag_i
);

    localparam int LINES = 1 << IDX_W;
    localparam int DEPTH = LINES << WRD_W;

    logic [31:0]      data_q [DEPTH];
    logic [TAG_W-1:0] tag_q  [LINES];

    // Registered read plus byte-masked data write and tag write.
    always_ff @(posedge clk) begin
        rd_tag_o  <= tag_q[rd_idx_i];
        rd_data_o <= data_q[{rd_idx_i, rd_word_i}];
        for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) begin
                data_q[{wr_idx_i, wr_word_i}][8*b +: 8] <= wr_data_i[8*b +: 8];
            end
        end
        if (tag_we_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-through, no-write-allocate data cache.
// Stalls the core during line refills and write-through stores.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_re,
    input  logic [3:0]  dcache_we,
    input  logic [31:0] dcache_din,
    output logic [31:0] dcache_dout,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_rw,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    output logic [3:0]  mem_req_mask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);

    localparam int WRD_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = tag_w(LINES, WORDS);
    localparam int IDX_LO = OFF_W + WRD_W;
    localparam int TAG_LO = IDX_LO + IDX_W;
    localparam logic [WRD_W-1:0] LAST = WRD_W'(WORDS - 1);

    state_t            state_q;
    logic [31:2]       addr_q;
    logic [3:0]        we_q;
    logic [31:0]       din_q;
    logic [WRD_W-1:0]  cnt_q;
    logic              hit_q;
    logic [LINES-1:0]  valid_q;
    logic [31:0]       res_q;
    logic              mvalid_q;
    logic              mrw_q;
    logic [31:0]       maddr_q;
    logic [31:0]       mdata_q;
    logic [3:0]        mmask_q;

    logic [IDX_W-1:0]  req_idx;
    logic [WRD_W-1:0]  req_word;
    logic [TAG_W-1:0]  req_tag;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_data;
    logic              hit;
    logic              is_st;
    logic              new_req;
    logic [WRD_W-1:0]  wr_word;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;
    logic              tag_we;
    logic              unused_ok;

    assign req_idx   = addr_q[TAG_LO-1:IDX_LO];
    assign req_word  = addr_q[IDX_LO-1:OFF_W];
    assign req_tag   = addr_q[31:TAG_LO];
    assign hit       = valid_q[req_idx] && (rd_tag == req_tag);
    assign is_st     = |we_q;
    assign new_req   = dcache_re | (|dcache_we);
    assign unused_ok = ^dcache_addr[OFF_W-1:0];

    assign dcache_dout   = (state_q == S_LOOKUP) ? rd_data : res_q;
    assign mem_req_valid = mvalid_q;
    assign mem_req_rw    = mrw_q;
    assign mem_req_addr  = maddr_q;
    assign mem_req_data  = mdata_q;
    assign mem_req_mask  = mmask_q;

    dcache_array #(
        .IDX_W(IDX_W),
        .WRD_W(WRD_W),
        .TAG_W(TAG_W)
    ) u_array (
        .clk      (clk),
        .rd_idx_i (dcache_addr[TAG_LO-1:IDX_LO]),
        .rd_word_i(dcache_addr[IDX_LO-1:OFF_W]),
        .rd_tag_o (rd_tag),
        .rd_data_o(rd_data),
        .wr_idx_i (req_idx),
        .wr_word_i(wr_word),
        .wr_be_i  (wr_be),
        .wr_data_i(wr_data),
        .tag_we_i (tag_we),
        .wr_tag_i (req_tag)
    );

    // Freeze the core on any miss, store or outstanding memory transfer.
    always_comb begin
        unique case (state_q)
            S_LOOKUP:                stall = is_st || !hit;
            S_RREQ, S_RFILL, S_WREQ: stall = 1'b1;
            default:                 stall = 1'b0;
        endcase
    end

    // Array writes: full-word refill beats, or a store merge on a hit.
    always_comb begin
        wr_word = req_word;
        wr_be   = 4'h0;
        wr_data = din_q;
        tag_we  = 1'b0;
        if (state_q == S_RFILL && mem_resp_valid) begin
            wr_word = cnt_q;
            wr_be   = 4'hF;
            wr_data = mem_resp_data;
            tag_we  = (cnt_q == LAST);
        end else if (state_q == S_WREQ && mem_req_ready && hit_q) begin
            wr_be = we_q;
        end
    end

    // Request capture whenever the core is not frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            we_q   <= '0;
            din_q  <= '0;
        end else if (!stall) begin
            addr_q <= dcache_addr[31:2];
            we_q   <= dcache_we;
            din_q  <= dcache_din;
        end
    end

    // Control FSM with registered memory-request outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            valid_q  <= '0;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            res_q    <= '0;
            mvalid_q <= 1'b0;
            mrw_q    <= 1'b0;
            maddr_q  <= '0;
            mdata_q  <= '0;
            mmask_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= new_req ? S_LOOKUP : S_IDLE;
                end
                S_LOOKUP: begin
                    if (is_st) begin
                        state_q  <= S_WREQ;
                        hit_q    <= hit;
                        mvalid_q <= 1'b1;
                        mrw_q    <= 1'b1;
                        maddr_q  <= {addr_q, 2'b00};
                        mdata_q  <= din_q;
                        mmask_q  <= we_q;
                    end else if (!hit) begin
                        state_q          <= S_RREQ;
                        valid_q[req_idx] <= 1'b0;
                        cnt_q            <= '0;
                        mvalid_q         <= 1'b1;
                        mrw_q            <= 1'b0;
                        maddr_q          <= {addr_q[31:IDX_LO],
                                             {WRD_W{1'b0}}, 2'b00};
                    end else begin
                        state_q <= new_req ? S_LOOKUP : S_IDLE;
                    end
                end
                S_RREQ: begin
                    if (mem_req_ready) begin
                        mvalid_q <= 1'b0;
                        state_q  <= S_RFILL;
                    end
                end
                S_RFILL: begin
                    if (mem_resp_valid) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == req_word) begin
                            res_q <= mem_resp_data;
                        end
                        if (cnt_q == LAST) begin
                            valid_q[req_idx] <= 1'b1;
                            state_q          <= S_DONE;
                        end
                    end
                end
                S_WREQ: begin
                    if (mem_req_ready) begin
                        mvalid_q <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a word-beat memory model.
// Table rows cover hits, misses, stores and eviction; sequences cover stalls and reset.
module tb_dcache_ctrl;

    localparam int WORDS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic [3:0]  mem_req_mask;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    dcache_ctrl #(.LINES(64), .WORDS(WORDS)) dut (
        .clk           (clk),
        .reset         (reset),
        .dcache_addr   (dcache_addr),
        .dcache_re     (dcache_re),
        .dcache_we     (dcache_we),
        .dcache_din    (dcache_din),
        .dcache_dout   (dcache_dout),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_mask  (mem_req_mask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int ready_delay = 0;
    int gap = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int unstable = 0;

    logic [31:0] mem [1024];

    int          dly = 0;
    int          gapc = 0;
    int          beat = 0;
    logic        beating = 1'b0;
    logic [31:0] rq_addr;
    logic [31:0] rq_data;
    logic [3:0]  rq_mask;
    logic        rq_rw;

    typedef struct {
        logic        re;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] din;
        logic        chk_d;
        logic [31:0] exp_d;
        int          exp_n;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ready after ready_delay cycles, beats separated by gap.
    always @(negedge clk) begin
        if (beating) begin
            if (gapc > 0) begin
                mem_resp_valid = 1'b0;
                gapc--;
            end else if (beat == WORDS) begin
                mem_resp_valid = 1'b0;
                beating = 1'b0;
            end else begin
                mem_resp_valid = 1'b1;
                mem_resp_data = mem[rq_addr[11:2] + 10'(beat)];
                beat++;
                gapc = (beat < WORDS) ? gap : 0;
            end
        end else if (mem_req_ready) begin
            mem_req_ready = 1'b0;
            dly = 0;
            if (rq_rw) begin
                for (int b = 0; b < 4; b++) begin
                    if (rq_mask[b]) begin
                        mem[rq_addr[11:2]][8*b +: 8] = rq_data[8*b +: 8];
                    end
                end
                wr_cnt++;
            end else begin
                rd_cnt++;
                beating = 1'b1;
                mem_resp_valid = 1'b1;
                mem_resp_data = mem[rq_addr[11:2]];
                beat = 1;
                gapc = gap;
            end
        end else if (mem_req_valid) begin
            if (dly == 0) begin
                rq_addr = mem_req_addr;
                rq_data = mem_req_data;
                rq_mask = mem_req_mask;
                rq_rw   = mem_req_rw;
            end else if (rq_addr !== mem_req_addr || rq_rw !== mem_req_rw ||
                         rq_data !== mem_req_data || rq_mask !== mem_req_mask) begin
                unstable++;
            end
            if (dly < ready_delay) begin
                dly++;
            end else begin
                mem_req_ready = 1'b1;
            end
        end
    end

    task automatic req(input logic r, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] q, output int n);
        dcache_re   = r;
        dcache_we   = w;
        dcache_addr = a;
        dcache_din  = d;
        @(posedge clk);
        @(negedge clk);
        n = 0;
        while (stall && n < 300) begin
            n++;
            @(negedge clk);
        end
        #1;
        q = dcache_dout;
        dcache_re = 1'b0;
        dcache_we = 4'h0;
    endtask

    task automatic run(input string name, input vec_t v);
        int          r0;
        int          w0;
        int          n;
        logic [31:0] q;
        r0 = rd_cnt;
        w0 = wr_cnt;
        req(v.re, v.we, v.addr, v.din, q, n);
        chk({name, " stall_cycles"}, n, v.exp_n);
        if (v.chk_d) begin
            chk({name, " dout"}, q, v.exp_d);
        end
        chk({name, " reads"}, rd_cnt - r0, v.exp_rd);
        chk({name, " writes"}, wr_cnt - w0, v.exp_wr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        int k;

        vt[0]  = '{1'b1, 4'h0, 32'h100, 32'h0,        1'b1, 32'h000000A0, 6, 1, 0};
        vt[1]  = '{1'b1, 4'h0, 32'h104, 32'h0,        1'b1, 32'h000000A1, 0, 0, 0};
        vt[2]  = '{1'b1, 4'h0, 32'h10C, 32'h0,        1'b1, 32'h000000A3, 0, 0, 0};
        vt[3]  = '{1'b0, 4'h2, 32'h104, 32'h00005500, 1'b0, 32'h0,        2, 0, 1};
        vt[4]  = '{1'b1, 4'h0, 32'h104, 32'h0,        1'b1, 32'h000055A1, 0, 0, 0};
        vt[5]  = '{1'b0, 4'hF, 32'h800, 32'hDEADBEEF, 1'b0, 32'h0,        2, 0, 1};
        vt[6]  = '{1'b1, 4'h0, 32'h800, 32'h0,        1'b1, 32'hDEADBEEF, 6, 1, 0};
        vt[7]  = '{1'b1, 4'h0, 32'h804, 32'h0,        1'b1, 32'h10000804, 0, 0, 0};
        vt[8]  = '{1'b1, 4'h0, 32'h500, 32'h0,        1'b1, 32'h10000500, 6, 1, 0};
        vt[9]  = '{1'b1, 4'h0, 32'h100, 32'h0,        1'b1, 32'h000000A0, 6, 1, 0};
        vt[10] = '{1'b1, 4'h0, 32'h104, 32'h0,        1'b1, 32'h000055A1, 0, 0, 0};
        vt[11] = '{1'b1, 4'hC, 32'h108, 32'h12340000, 1'b0, 32'h0,        2, 0, 1};
        vt[12] = '{1'b1, 4'h0, 32'h108, 32'h0,        1'b1, 32'h123400A2, 0, 0, 0};
        vt[13] = '{1'b0, 4'h1, 32'h504, 32'h00000077, 1'b0, 32'h0,        2, 0, 1};
        vt[14] = '{1'b1, 4'h0, 32'h108, 32'h0,        1'b1, 32'h123400A2, 0, 0, 0};
        vt[15] = '{1'b1, 4'h0, 32'h504, 32'h0,        1'b1, 32'h10000577, 6, 1, 0};
        vt[16] = '{1'b1, 4'h0, 32'h10C, 32'h0,        1'b1, 32'h000000A3, 6, 1, 0};

        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h1000_0000 + 32'(i * 4);
        end
        mem[10'h40] = 32'hA0;
        mem[10'h41] = 32'hA1;
        mem[10'h42] = 32'hA2;
        mem[10'h43] = 32'hA3;

        reset          = 1'b0;
        dcache_addr    = '0;
        dcache_re      = 1'b0;
        dcache_we      = 4'h0;
        dcache_din     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        repeat (2) @(negedge clk);
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("reset mem_req_rw", {31'b0, mem_req_rw}, 32'd0);
        chk("reset dout", dcache_dout, 32'd0);
        chk("reset mem_req_addr", mem_req_addr, 32'd0);
        chk("reset mem_req_data", mem_req_data, 32'd0);
        chk("reset mem_req_mask", {28'b0, mem_req_mask}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run($sformatf("row%0d", i), vt[i]);
        end

        ready_delay = 5;
        gap = 2;
        unstable = 0;
        run("slow_load", '{1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 32'h10000200, 17, 1, 0});
        run("slow_store", '{1'b0, 4'hF, 32'h200, 32'hCAFEF00D, 1'b0, 32'h0, 7, 0, 1});
        chk("slow req_fields_stable", unstable, 32'd0);
        run("slow_hit", '{1'b1, 4'h0, 32'h200, 32'h0, 1'b1, 32'hCAFEF00D, 0, 0, 0});
        ready_delay = 0;
        gap = 0;

        dcache_re   = 1'b1;
        dcache_addr = 32'h300;
        @(posedge clk);
        #1;
        dcache_re = 1'b0;
        nb = 0;
        k = 0;
        while (nb < 3 && k < 100) begin
            @(posedge clk);
            if (mem_resp_valid) nb++;
            k++;
        end
        #1;
        reset = 1'b0;
        #1;
        chk("midfill beats_before_reset", nb, 32'd3);
        chk("midfill stall", {31'b0, stall}, 32'd0);
        chk("midfill mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("midfill dout", dcache_dout, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        run("after_rst_300", '{1'b1, 4'h0, 32'h300, 32'h0, 1'b1, 32'h10000300, 6, 1, 0});
        run("after_rst_100", '{1'b1, 4'h0, 32'h100, 32'h0, 1'b1, 32'h000000A0, 6, 1, 0});
        run("after_rst_304", '{1'b1, 4'h0, 32'h304, 32'h0, 1'b1, 32'h10000304, 0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
